// File: rtl/object_drop.sv
// object_drop: takes spawn X positions from the object spawner, drops one
// object down the playfield at a fixed pixel rate, and decides whether the
// paddle caught or missed it when it reaches the paddle row.
module object_drop #(
  parameter int SCREEN_W           = 640,
  parameter int UNDEFINED_POSITION = 1000,
  parameter int OBJ_SIZE           = 16,
  parameter int PLAYER_W           = 64,
  parameter int PLAYER_Y           = 448,
  parameter int STEP_TICKS         = 100000,
  parameter int SCORE_W            = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        object_position,
  input  logic [10:0]        player_x,
  input  logic               pause,
  output logic [10:0]        obj_x,
  output logic [10:0]        obj_y,
  output logic               obj_active,
  output logic               caught,
  output logic               missed,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss_count
);

  // A one-tick step period still needs a 1-bit counter so the widths stay legal.
  localparam int CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STEP_TICKS - 1);
  localparam logic [10:0]      UNDEF_POS = 11'(UNDEFINED_POSITION);
  localparam logic [10:0]      SPAWN_MAX = 11'(SCREEN_W - OBJ_SIZE);
  localparam logic [10:0]      LAND_Y    = 11'(PLAYER_Y - OBJ_SIZE);
  localparam logic [11:0]      SIZE_12   = 12'(OBJ_SIZE);
  localparam logic [11:0]      PW_12     = 12'(PLAYER_W);

  typedef enum logic [1:0] {IDLE, FALL, RESOLVE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   step_cnt, step_cnt_n;
  logic [10:0]        obj_x_n, obj_y_n;
  logic               obj_active_n, caught_n, missed_n;
  logic [SCORE_W-1:0] score_n, miss_count_n;
  logic               overlap;

  // Register every piece of state; reset abandons any object in flight silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      step_cnt   <= '0;
      obj_x      <= UNDEF_POS;
      obj_y      <= '0;
      obj_active <= 1'b0;
      caught     <= 1'b0;
      missed     <= 1'b0;
      score      <= '0;
      miss_count <= '0;
    end else begin
      state      <= state_n;
      step_cnt   <= step_cnt_n;
      obj_x      <= obj_x_n;
      obj_y      <= obj_y_n;
      obj_active <= obj_active_n;
      caught     <= caught_n;
      missed     <= missed_n;
      score      <= score_n;
      miss_count <= miss_count_n;
    end
  end

  // Next-state logic: accept a spawn, step the fall, then resolve against the paddle.
  always_comb begin
    state_n      = state;
    step_cnt_n   = step_cnt;
    obj_x_n      = obj_x;
    obj_y_n      = obj_y;
    obj_active_n = obj_active;
    caught_n     = 1'b0;
    missed_n     = 1'b0;
    score_n      = score;
    miss_count_n = miss_count;

    // Widened to 12 bits so the edge sums cannot wrap; touching edges do not overlap.
    overlap = (({1'b0, obj_x} + SIZE_12) > {1'b0, player_x}) &&
              ({1'b0, obj_x} < ({1'b0, player_x} + PW_12));

    case (state)
      IDLE: begin
        if ((object_position != UNDEF_POS) && (object_position <= SPAWN_MAX)) begin
          obj_x_n      = object_position;
          obj_y_n      = '0;
          obj_active_n = 1'b1;
          step_cnt_n   = '0;
          state_n      = FALL;
        end
      end
      FALL: begin
        if (!pause) begin
          if (step_cnt == CNT_MAX) begin
            step_cnt_n = '0;
            obj_y_n    = obj_y + 11'd1;
            if ((obj_y + 11'd1) == LAND_Y) state_n = RESOLVE;
          end else begin
            step_cnt_n = step_cnt + CNT_W'(1);
          end
        end
      end
      RESOLVE: begin
        if (overlap) begin
          caught_n = 1'b1;
          if (score != '1) score_n = score + SCORE_W'(1);
        end else begin
          missed_n = 1'b1;
          if (miss_count != '1) miss_count_n = miss_count + SCORE_W'(1);
        end
        obj_active_n = 1'b0;
        obj_x_n      = UNDEF_POS;
        obj_y_n      = '0;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/object_drop.md
Name: object_drop

Overview:
- Downstream consumer of the object spawner's 11-bit object_position stream.
- On a valid spawn X, animates a single object falling down the playfield at a fixed pixel rate.
- Resolves catch or miss against the player paddle at the paddle row, and keeps score and miss counters for the display and game-control logic.

Parameters:
- SCREEN_W, 640: playfield width in pixels.
- UNDEFINED_POSITION, 1000: spawner code meaning "no object".
- OBJ_SIZE, 16: object square side in pixels.
- PLAYER_W, 64: paddle width in pixels.
- PLAYER_Y, 448: paddle top row. The object lands when obj_y == PLAYER_Y-OBJ_SIZE.
- STEP_TICKS, 100000: clk cycles per 1-pixel fall step. Must be ≥1.
- SCORE_W, 16: width of the score and miss counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- object_position  in  11  spawn X from the spawner. UNDEFINED_POSITION means none.
- player_x  in  11  paddle left edge, sampled live.
- pause  in  1  freezes fall timing while high.
- obj_x  out  11  current object left edge. UNDEFINED_POSITION when inactive.
- obj_y  out  11  current object top row. 0 when inactive.
- obj_active  out  1  object on screen.
- caught  out  1  one-cycle pulse on a catch.
- missed  out  1  one-cycle pulse on a miss.
- score  out  SCORE_W  number of catches.
- miss_count  out  SCORE_W  number of misses.

Behaviour:
- Reset values: obj_x=UNDEFINED_POSITION, obj_y=0, obj_active=0, caught=0, missed=0, score=0, miss_count=0, step counter=0, state=IDLE.
- rst has priority over all other events and aborts any fall in progress; no caught or missed pulse is produced.
- FSM states: IDLE, FALL, RESOLVE.
- IDLE, spawn accepted:
  - Condition: object_position != UNDEFINED_POSITION and object_position <= SCREEN_W-OBJ_SIZE.
  - Action: obj_x <= object_position, obj_y <= 0, obj_active <= 1, step counter <= 0, go to FALL.
  - Latency: a spawn value present at edge N shows on the outputs after edge N (one cycle).
- IDLE, other values: out-of-range values other than UNDEFINED_POSITION are ignored; the block stays in IDLE.
- FALL, timing:
  - pause=0: step counter increments each cycle. When it equals STEP_TICKS-1 it clears and obj_y increments by 1.
  - pause=1: counter and obj_y hold.
- FALL, landing: when the increment makes obj_y == PLAYER_Y-OBJ_SIZE, the next state is RESOLVE. The final obj_y is held.
- FALL: object_position is ignored; only one object is in flight at a time and a spawn during FALL is dropped.
- RESOLVE, single cycle, evaluated on player_x at that edge. pause does not delay it.
  - Overlap test, computed in 12-bit unsigned: (obj_x+OBJ_SIZE > player_x) and (obj_x < player_x+PLAYER_W).
  - Overlap true: caught=1 for one cycle; score increments, saturating at all-ones.
  - Overlap false: missed=1 for one cycle; miss_count increments, saturating at all-ones.
  - Then: obj_active <= 0, obj_x <= UNDEFINED_POSITION, obj_y <= 0, go to IDLE.
  - The pulses and the deactivation appear after the same edge.
- Re-spawn: a valid spawn value is first accepted in the IDLE cycle after RESOLVE, so there is a minimum of one IDLE cycle between objects.
- Edge contact counts as a miss: obj_x+OBJ_SIZE == player_x, or obj_x == player_x+PLAYER_W.
- Fall duration from spawn to RESOLVE: (PLAYER_Y-OBJ_SIZE)*STEP_TICKS unpaused cycles, plus the RESOLVE cycle.

Test Plan:
Bench parameters: STEP_TICKS=2, PLAYER_Y=40, OBJ_SIZE=8, PLAYER_W=16, SCREEN_W=64.
- Reset and idle:
  - Stimulus: hold rst 3 cycles, then object_position=1000 for 20 cycles.
  - Required: obj_x=1000, obj_y=0, obj_active=0, score=0, miss_count=0, no caught or missed pulses.
- Catch:
  - Stimulus: object_position=20 for one cycle, player_x=16.
  - Required: obj_active=1 and obj_x=20 one cycle later; obj_y increments every 2 cycles; obj_y reaches 32 after 64 cycles; one caught pulse; score=1; then obj_x=1000.
- Miss with edge contact:
  - Stimulus: spawn at 20 with player_x=28, then repeat with player_x=4.
  - Required: both runs produce a missed pulse; miss_count=2; score unchanged.
- Pause and ignored spawns:
  - Stimulus: spawn at 10, assert pause for 50 cycles mid-fall, present object_position=30 during FALL.
  - Required: obj_y frozen throughout the pause; obj_x stays 10; the spawn of 30 is dropped; total fall takes 64+50 cycles.
- Out-of-range spawn:
  - Stimulus: object_position=60 (>56) while IDLE.
  - Required: no spawn; obj_active stays 0.
- Reset mid-fall and saturation:
  - Stimulus: assert rst at obj_y=15.
  - Required: all outputs return to reset values next cycle; no caught or missed pulse.
  - Stimulus: with SCORE_W=2, perform 5 catches.
  - Required: score saturates at 3.
